// File: rtl/vga_board_render_if.sv
// Board transfer channel between game logic and the VGA pixel stage.
//   board_in    : 64-bit board, tile (r,c) exponent at [4*(4r+c) +: 4]
//   board_valid : board_in carries a new board
//   board_ready : renderer staging buffer is free
//   board_shown : one-cycle pulse when a staged board becomes the displayed board
// A transfer happens on a clock edge where board_valid && board_ready.
interface vga_board_render_if;
  logic [63:0] board_in;
  logic        board_valid;
  logic        board_ready;
  logic        board_shown;

  modport master (
    output board_in,
    output board_valid,
    input  board_ready,
    input  board_shown
  );

  modport slave (
    input  board_in,
    input  board_valid,
    output board_ready,
    output board_shown
  );
endinterface

// File: rtl/vga_board_render.sv
// Pixel stage placed directly after the VGA timing generator. Maps each visible
// pixel onto a 4x4 2048 board and produces 3-3-2 RGB plus syncs re-aligned to
// the two-register pixel pipeline.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   hc, vc          : horizontal / vertical counters from the timing generator
//   vidon           : visible-area flag
//   Hsync, Vsync    : active-low syncs from the timing generator
//   board_if        : board transfer channel (slave side)
//   rgb             : {R[2:0],G[2:0],B[1:0]}
//   Hsync_o, Vsync_o: syncs delayed to line up with rgb
// Incoming boards are held in a staging buffer and copied to the displayed
// (shadow) buffer only during vertical blanking, so a frame never tears.
module vga_board_render #(
  parameter int unsigned HBP  = 144,
  parameter int unsigned VBP  = 31,
  parameter int unsigned VFP  = 511,
  parameter int unsigned BX   = 100,
  parameter int unsigned BY   = 20,
  parameter int unsigned TILE = 100,
  parameter int unsigned GAP  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               hc,
  input  logic [9:0]               vc,
  input  logic                     vidon,
  input  logic                     Hsync,
  input  logic                     Vsync,
  vga_board_render_if.slave        board_if,
  output logic [7:0]               rgb,
  output logic                     Hsync_o,
  output logic                     Vsync_o
);

  localparam int unsigned PITCH = TILE + GAP;

  localparam logic [9:0] L_HOFF = 10'(HBP + 1);
  localparam logic [9:0] L_VOFF = 10'(VBP + 1);
  localparam logic [9:0] L_VBP  = 10'(VBP);
  localparam logic [9:0] L_VFP  = 10'(VFP);
  localparam logic [9:0] L_BX   = 10'(BX);
  localparam logic [9:0] L_BY   = 10'(BY);
  localparam logic [9:0] L_TILE = 10'(TILE);
  localparam logic [9:0] L_P1   = 10'(PITCH);
  localparam logic [9:0] L_P2   = 10'(2 * PITCH);
  localparam logic [9:0] L_P3   = 10'(3 * PITCH);
  localparam logic [9:0] L_SPAN = 10'(4 * PITCH);

  localparam logic [7:0] C_BLANK = 8'h00;
  localparam logic [7:0] C_BG    = 8'h24;
  localparam logic [7:0] C_GAP   = 8'h92;

  // ---------------------------------------------------------------------------
  // Board buffering
  // ---------------------------------------------------------------------------
  typedef enum logic {
    FREE,
    PENDING
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_staging;
  logic [63:0] r_shadow;
  logic        w_vblank;
  logic        w_accept;
  logic        w_commit;
  logic        w_ready;

  assign w_vblank = (vc <= L_VBP) || (vc >= L_VFP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FREE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      FREE: begin
        w_ready = 1'b1;
        if (board_if.board_valid) begin
          w_accept = 1'b1;
          w_next   = PENDING;
        end
      end
      PENDING: begin
        if (w_vblank) begin
          w_commit = 1'b1;
          w_next   = FREE;
        end
      end
      default: w_next = FREE;
    endcase
  end

  assign board_if.board_ready = w_ready;
  assign board_if.board_shown = w_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_staging <= '0;
      r_shadow  <= '0;
    end else begin
      if (w_accept) begin
        r_staging <= board_if.board_in;
      end
      if (w_commit) begin
        r_shadow <= r_staging;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Geometry: one axis at a time, compared against constant tile boundaries.
  // Returns {inside_board, in_gutter, tile_index[1:0]}.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] axis_map(input logic [9:0] p, input logic [9:0] org);
    logic [9:0] d;
    logic [9:0] t0;
    logic [1:0] idx;
    logic       inr;
    inr = (p >= org) && (p < (org + L_SPAN));
    d   = p - org;
    if (d >= L_P3) begin
      idx = 2'd3;
      t0  = L_P3;
    end else if (d >= L_P2) begin
      idx = 2'd2;
      t0  = L_P2;
    end else if (d >= L_P1) begin
      idx = 2'd1;
      t0  = L_P1;
    end else begin
      idx = 2'd0;
      t0  = '0;
    end
    // Offset within the pitch past the tile side means the trailing gutter
    return {inr, inr && ((d - t0) >= L_TILE), idx};
  endfunction

  function automatic logic [7:0] palette(input logic [3:0] e);
    case (e)
      4'd0:    return 8'hDB;
      4'd1:    return 8'hFF;
      4'd2:    return 8'hFE;
      4'd3:    return 8'hF4;
      4'd4:    return 8'hF0;
      4'd5:    return 8'hE8;
      4'd6:    return 8'hE0;
      4'd7:    return 8'hFC;
      4'd8:    return 8'hF8;
      4'd9:    return 8'hF9;
      4'd10:   return 8'hFA;
      4'd11:   return 8'hFB;
      default: return 8'h49;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 1: pixel classification
  // ---------------------------------------------------------------------------
  logic [9:0] w_px;
  logic [9:0] w_py;
  logic [3:0] w_xm;
  logic [3:0] w_ym;

  // Outside the visible window these wrap, but vid masks the result anyway
  assign w_px = hc - L_HOFF;
  assign w_py = vc - L_VOFF;
  assign w_xm = axis_map(w_px, L_BX);
  assign w_ym = axis_map(w_py, L_BY);

  logic       r_vid1;
  logic       r_hs1;
  logic       r_vs1;
  logic       r_inb1;
  logic       r_gap1;
  logic [1:0] r_row1;
  logic [1:0] r_col1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vid1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_inb1 <= 1'b0;
      r_gap1 <= 1'b0;
      r_row1 <= '0;
      r_col1 <= '0;
    end else begin
      r_vid1 <= vidon;
      r_hs1  <= Hsync;
      r_vs1  <= Vsync;
      r_inb1 <= w_xm[3] && w_ym[3];
      r_gap1 <= w_xm[3] && w_ym[3] && (w_xm[2] || w_ym[2]);
      r_row1 <= w_ym[1:0];
      r_col1 <= w_xm[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour lookup
  // ---------------------------------------------------------------------------
  logic [3:0] w_exp;
  logic [7:0] w_rgb;

  assign w_exp = r_shadow[{r_row1, r_col1, 2'b00} +: 4];

  always_comb begin
    w_rgb = C_BLANK;
    if (!r_vid1) begin
      w_rgb = C_BLANK;
    end else if (!r_inb1) begin
      w_rgb = C_BG;
    end else if (r_gap1) begin
      w_rgb = C_GAP;
    end else begin
      w_rgb = palette(w_exp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb     <= '0;
      Hsync_o <= 1'b1;
      Vsync_o <= 1'b1;
    end else begin
      rgb     <= w_rgb;
      Hsync_o <= r_hs1;
      Vsync_o <= r_vs1;
    end
  end

endmodule

// File: tb/tb_vga_board_render.sv
// Testbench for vga_board_render. The bench plays the timing generator,
// driving hc/vc directly to chosen screen positions. Each checked pixel pushes
// its hand-computed colour and syncs into a scoreboard; a monitor compares the
// DUT output two clocks later. Handshake signals are checked inline.
module tb_vga_board_render;

  logic       clk;
  logic       rst_n;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       vidon;
  logic       Hsync;
  logic       Vsync;
  logic [7:0] rgb;
  logic       Hsync_o;
  logic       Vsync_o;

  vga_board_render_if bus ();

  vga_board_render #(
    .HBP (144),
    .VBP (31),
    .VFP (511),
    .BX  (100),
    .BY  (20),
    .TILE(100),
    .GAP (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hc      (hc),
    .vc      (vc),
    .vidon   (vidon),
    .Hsync   (Hsync),
    .Vsync   (Vsync),
    .board_if(bus),
    .rgb     (rgb),
    .Hsync_o (Hsync_o),
    .Vsync_o (Vsync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         due;
    logic [9:0] exp;
    string      nm;
  } ent_t;

  ent_t sb[$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one timing-generator sample; optionally expect its pixel two clocks on.
  task automatic set_px(input int h, input int v, input bit chk,
                        input logic [7:0] e, input string nm);
    logic hs;
    logic vs;
    hs    = (h >= 96);
    vs    = (v >= 2);
    hc    = 10'(h);
    vc    = 10'(v);
    vidon = (h >= 145) && (h <= 783) && (v >= 32) && (v <= 510);
    Hsync = hs;
    Vsync = vs;
    if (chk) sb.push_back('{due: cyc + 2, exp: {e, hs, vs}, nm: nm});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: output is valid every cycle, so entries fall due by cycle number.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          check({e.nm, "_missed"}, 16'(e.due), 16'(cyc));
        end else begin
          check(e.nm, {6'd0, rgb, Hsync_o, Vsync_o}, {6'd0, e.exp});
        end
      end
    end
  end

  localparam logic [63:0] B3 = 64'hB000_0000_0000_0001;  // (0,0)=1, (3,3)=11
  localparam logic [63:0] BA = 64'h2222_2222_2222_2222;  // all tiles 4
  localparam logic [63:0] BB = 64'h0000_0000_0D00_0000;  // (1,2)=13
  localparam logic [63:0] B6 = 64'h0000_0000_0000_0001;  // (0,0)=1

  initial begin
    rst_n           = 1'b0;
    bus.board_in    = '0;
    bus.board_valid = 1'b0;
    set_px(0, 0, 0, 8'h00, "");
    repeat (3) step();

    // Reset state (syncs driven low, outputs must still be idle-high)
    check("rst_rgb",   16'(rgb), 16'h00);
    check("rst_hsync", 16'(Hsync_o), 16'h1);
    check("rst_vsync", 16'(Vsync_o), 16'h1);
    check("rst_ready", 16'(bus.board_ready), 16'h1);
    check("rst_shown", 16'(bus.board_shown), 16'h0);
    rst_n = 1'b1;
    step();

    // 1: empty board
    set_px(295, 102, 1, 8'hDB, "t1_tile_150_70"); step();
    set_px(350, 102, 1, 8'h92, "t1_gap_205_70");  step();
    set_px(195,  82, 1, 8'h24, "t1_bg_50_50");    step();
    set_px(100, 100, 1, 8'h00, "t1_blank_hc100"); step();

    // 2: latency and sync alignment
    set_px(144, 32, 1, 8'h00, "t2_hc144");   step();
    set_px(145, 32, 1, 8'h24, "t2_x0y0");    step();
    set_px(146, 32, 1, 8'h24, "t2_x1y0");    step();
    set_px(799, 100, 1, 8'h00, "t2_hs_hi");  step();
    set_px(0,   100, 1, 8'h00, "t2_hs_fall"); step();
    set_px(1,   100, 1, 8'h00, "t2_hs_low"); step();
    set_px(10,    1, 1, 8'h00, "t2_vs_low"); step();
    set_px(10,    2, 1, 8'h00, "t2_vs_hi");  step();

    // 3: board sent mid-frame, shown after vblank
    bus.board_in    = B3;
    bus.board_valid = 1'b1;
    set_px(295, 102, 1, 8'hDB, "t3_pre");
    #1 check("t3_ready_free", 16'(bus.board_ready), 16'h1);
    step();
    bus.board_valid = 1'b0;
    set_px(295, 102, 1, 8'hDB, "t3_nochange_a");
    #1 check("t3_ready_pend", 16'(bus.board_ready), 16'h0);
    step();
    set_px(625, 432, 1, 8'hDB, "t3_nochange_b"); step();
    set_px(0, 510, 0, 8'h00, "");
    #1 check("t3_shown_vc510", 16'(bus.board_shown), 16'h0);
    step();
    set_px(0, 511, 0, 8'h00, "");
    #1 check("t3_shown_vc511", 16'(bus.board_shown), 16'h1);
    step();
    set_px(0, 512, 0, 8'h00, "");
    #1 check("t3_shown_after", 16'(bus.board_shown), 16'h0);
    check("t3_ready_after", 16'(bus.board_ready), 16'h1);
    step();
    set_px(295, 102, 1, 8'hFF, "t3_tile00_FF"); step();
    set_px(625, 432, 1, 8'hFB, "t3_tile33_FB"); step();
    set_px(195,  82, 1, 8'h24, "t3_bg");        step();

    // 4: back-to-back words
    bus.board_in    = BA;
    bus.board_valid = 1'b1;
    set_px(295, 102, 1, 8'hFF, "t4_pre");
    #1 check("t4_ready_a", 16'(bus.board_ready), 16'h1);
    step();
    bus.board_in = BB;
    for (int i = 0; i < 3; i++) begin
      set_px(295, 102, 1, 8'hFF, "t4_hold_pix");
      #1 check("t4_hold_ready", 16'(bus.board_ready), 16'h0);
      step();
    end
    set_px(0, 0, 0, 8'h00, "");
    #1 check("t4_commit_a", 16'(bus.board_shown), 16'h1);
    check("t4_ready_commit", 16'(bus.board_ready), 16'h0);
    step();
    set_px(0, 1, 0, 8'h00, "");
    #1 check("t4_ready_b", 16'(bus.board_ready), 16'h1);
    check("t4_shown_gap", 16'(bus.board_shown), 16'h0);
    step();
    bus.board_valid = 1'b0;
    set_px(0, 2, 0, 8'h00, "");
    #1 check("t4_commit_b", 16'(bus.board_shown), 16'h1);
    step();
    set_px(0, 3, 0, 8'h00, "");
    #1 check("t4_idle_ready", 16'(bus.board_ready), 16'h1);
    step();

    // 5: exponent 13 and board edges
    set_px(515, 212, 1, 8'h49, "t5_tile12_e13");  step();
    set_px(295, 102, 1, 8'hDB, "t5_tile00_empty"); step();
    set_px(684, 212, 1, 8'h92, "t5_x539");        step();
    set_px(685, 212, 1, 8'h24, "t5_x540");        step();
    set_px(244,  52, 1, 8'h24, "t5_x99");         step();
    set_px(245,  52, 1, 8'hDB, "t5_x100");        step();
    set_px(344,  52, 1, 8'hDB, "t5_x199");        step();
    set_px(345,  52, 1, 8'h92, "t5_x200");        step();
    set_px(295, 491, 1, 8'h92, "t5_y459");        step();
    set_px(295, 492, 1, 8'h24, "t5_y460");        step();

    // 6: reset while a board is pending
    bus.board_in    = B6;
    bus.board_valid = 1'b1;
    set_px(295, 232, 1, 8'hDB, "t6_pre");
    #1 check("t6_ready", 16'(bus.board_ready), 16'h1);
    step();
    bus.board_valid = 1'b0;
    set_px(295, 232, 1, 8'hDB, "t6_pix_a"); step();
    set_px(10,  232, 0, 8'h00, "");          step();
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_rgb",   16'(rgb), 16'h00);
    check("t6_rst_hsync", 16'(Hsync_o), 16'h1);
    check("t6_rst_vsync", 16'(Vsync_o), 16'h1);
    repeat (3) step();
    check("t6_rst_hold_hs", 16'(Hsync_o), 16'h1);
    rst_n = 1'b1;
    set_px(0, 0, 0, 8'h00, "");
    #1 check("t6_no_commit", 16'(bus.board_shown), 16'h0);
    check("t6_ready_rel", 16'(bus.board_ready), 16'h1);
    step();
    set_px(0, 1, 0, 8'h00, ""); step();
    set_px(295, 102, 1, 8'hDB, "t6_empty_00"); step();
    set_px(625, 432, 1, 8'hDB, "t6_empty_33"); step();

    // Drain scoreboard
    set_px(0, 100, 0, 8'h00, "");
    repeat (3) step();
    check("sb_drained", 16'(sb.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
